hack_screen_scanout: RTL

Display stage directly downstream of the Hack screen memory (8K x 16, 512x256 mono). It generates 640x480@60 VGA timing and fetches screen words over a single read port with 1-clk read latency. It serialises each word into pixels and outputs the 512x256 image centred in the visible area with a white border. Pixel rate is set by a clock-enable, so the block runs on the system clock.

---
 rtl/hack_video_pkg.sv | 45 ++++
 rtl/hack_vga_timing.sv | 58 +++++
 rtl/hack_screen_scanout.sv | 79 +++++++
 3 files changed

// File: rtl/hack_video_pkg.sv
// hack_video_pkg: VGA 640x480 timing, Hack 512x256 image geometry, counter/address/word types and span helpers
package hack_video_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_OFF = 64;
  localparam int Y_OFF = 112;
  localparam int IMG_W = 512;
  localparam int IMG_H = 256;
  localparam int WORD_W = 16;
  localparam int WORDS_PER_ROW = 32;
  localparam int ADDR_W = 13;
  localparam int CNT_W = 10;
  localparam int WORD_BITS = $clog2(WORDS_PER_ROW);
  localparam int PIX_BITS = $clog2(WORD_W);
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;
  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};
  function automatic cnt_t to_cnt(int v);
    return cnt_t'(v);
  endfunction
  function automatic logic in_span(cnt_t c, int lo, int len);
    cnt_t d;
    d = c - to_cnt(lo);
    return d < to_cnt(len);
  endfunction
  function automatic logic word_edge(cnt_t c, int lo, int len);
    cnt_t d;
    d = c - to_cnt(lo);
    return d < to_cnt(len) && d[PIX_BITS-1:0] == '0;
  endfunction
endpackage

// File: rtl/hack_vga_timing.sv
// hack_vga_timing: pix_ce-paced h/v counters (h_cnt_o/v_cnt_o) with registered hsync_o/vsync_o/de_o and one-clk frame_start_o
module hack_vga_timing
  import hack_video_pkg::*;
#(
  parameter int H_ACTIVE = hack_video_pkg::H_ACTIVE,
  parameter int H_FP = hack_video_pkg::H_FP,
  parameter int H_SYNC = hack_video_pkg::H_SYNC,
  parameter int H_BP = hack_video_pkg::H_BP,
  parameter int V_ACTIVE = hack_video_pkg::V_ACTIVE,
  parameter int V_FP = hack_video_pkg::V_FP,
  parameter int V_SYNC = hack_video_pkg::V_SYNC,
  parameter int V_BP = hack_video_pkg::V_BP
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_ce_i,
  output cnt_t h_cnt_o,
  output cnt_t v_cnt_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic de_o,
  output logic frame_start_o
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  cnt_t h_q, h_d, v_q, v_d;
  sync_t sync_q, sync_d;
  logic fs_q, fs_d, h_wrap, v_wrap;
  always_comb begin
    h_wrap = h_q == to_cnt(H_TOT - 1);
    v_wrap = v_q == to_cnt(V_TOT - 1);
    h_d = pix_ce_i ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
    v_d = (pix_ce_i && h_wrap) ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
    sync_d = pix_ce_i ? sync_t'{hsync: !in_span(h_q, H_ACTIVE + H_FP, H_SYNC),
                                vsync: !in_span(v_q, V_ACTIVE + V_FP, V_SYNC),
                                de: in_span(h_q, 0, H_ACTIVE) && in_span(v_q, 0, V_ACTIVE)} : sync_q;
    fs_d = pix_ce_i && h_wrap && v_wrap;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
      sync_q <= SYNC_IDLE;
      fs_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      sync_q <= sync_d;
      fs_q <= fs_d;
    end
  end
  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;
  assign hsync_o = sync_q.hsync;
  assign vsync_o = sync_q.vsync;
  assign de_o = sync_q.de;
  assign frame_start_o = fs_q;
endmodule

// File: rtl/hack_screen_scanout.sv
// hack_screen_scanout: VGA scanout of Hack screen RAM (scr_addr/scr_rd/scr_data) to hsync/vsync/de/pixel with frame_start, paced by pix_ce
module hack_screen_scanout
  import hack_video_pkg::*;
#(
  parameter int H_ACTIVE = hack_video_pkg::H_ACTIVE,
  parameter int H_FP = hack_video_pkg::H_FP,
  parameter int H_SYNC = hack_video_pkg::H_SYNC,
  parameter int H_BP = hack_video_pkg::H_BP,
  parameter int V_ACTIVE = hack_video_pkg::V_ACTIVE,
  parameter int V_FP = hack_video_pkg::V_FP,
  parameter int V_SYNC = hack_video_pkg::V_SYNC,
  parameter int V_BP = hack_video_pkg::V_BP,
  parameter int X_OFF = hack_video_pkg::X_OFF,
  parameter int Y_OFF = hack_video_pkg::Y_OFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  output logic [ADDR_W-1:0] scr_addr,
  output logic              scr_rd,
  input  logic [WORD_W-1:0] scr_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              pixel,
  output logic              frame_start
);
  cnt_t h_cnt, v_cnt, row, fx;
  logic img_line, img_col, fetch, load, rd_q, rd_d, pix_q, pix_d;
  addr_t addr_q, addr_d;
  word_t hold_q, hold_d, shift_q, shift_d;
  hack_vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk),
    .reset(reset),
    .pix_ce_i(pix_ce),
    .h_cnt_o(h_cnt),
    .v_cnt_o(v_cnt),
    .hsync_o(hsync),
    .vsync_o(vsync),
    .de_o(de),
    .frame_start_o(frame_start)
  );
  // Word k is fetched two pixels ahead of its first column and loaded one pixel ahead;
  // with continuous pix_ce the capture and load share an edge, so the load bypasses hold.
  always_comb begin
    row = v_cnt - to_cnt(Y_OFF);
    fx = h_cnt - to_cnt(X_OFF - 2);
    img_line = in_span(v_cnt, Y_OFF, IMG_H);
    img_col = in_span(h_cnt, X_OFF, IMG_W);
    fetch = img_line && word_edge(h_cnt, X_OFF - 2, IMG_W);
    load = img_line && word_edge(h_cnt, X_OFF - 1, IMG_W);
    rd_d = pix_ce && fetch;
    addr_d = rd_d ? ((addr_t'(row) << WORD_BITS) | addr_t'(fx >> PIX_BITS)) : addr_q;
    hold_d = rd_q ? scr_data : hold_q;
    shift_d = !pix_ce ? shift_q : load ? hold_d : (img_line && img_col) ? shift_q >> 1 : shift_q;
    pix_d = pix_ce ? (img_line && img_col && shift_q[0]) : pix_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= 1'b0;
      addr_q <= '0;
      hold_q <= '0;
      shift_q <= '0;
      pix_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      addr_q <= addr_d;
      hold_q <= hold_d;
      shift_q <= shift_d;
      pix_q <= pix_d;
    end
  end
  assign scr_rd = rd_q;
  assign scr_addr = addr_q;
  assign pixel = pix_q;
endmodule
